// File: rtl/run_ctrl_pkg.sv
// Shared state encodings and default parameter values for the run-control unit.
package run_ctrl_pkg;

  localparam int unsigned STATE_W         = 2;
  localparam int unsigned PC_W_DEF        = 8;
  localparam int unsigned BP_NUM_DEF      = 2;
  localparam int unsigned STEP_CNT_W_DEF  = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DBNC_W_DEF      = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_HALT     = 2'd1,
    ST_STEPPING = 2'd2
  } state_e;

endpackage

// File: rtl/run_ctrl_if.sv
// CPU-side link of the run-control unit: fetch PC, pipeline enable, halt status, regfile debug handshake.
interface run_ctrl_if
  import run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
);

  logic [PC_W-1:0] cpu_PC;
  logic            cpu_en;
  logic            halted;
  logic            dbg_request;
  logic            dbg_grant;

  modport master (
    output cpu_PC,
    output dbg_request,
    input  cpu_en,
    input  halted,
    input  dbg_grant
  );

  modport slave (
    input  cpu_PC,
    input  dbg_request,
    output cpu_en,
    output halted,
    output dbg_grant
  );

endinterface

// File: rtl/run_ctrl_btn_debounce.sv
// Synchroniser plus debounce for one async board input; level moves after 2**DBNC_W stable cycles.
module btn_debounce
  import run_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DBNC_W      = DBNC_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [DBNC_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DBNC_W-1:0]      cnt_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Any disagreement with the accepted level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_out == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        level <= sync_out;
        rise  <= sync_out;
        fall  <= !sync_out;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run-control unit: PAUSE/STEP switches, multi-cycle step bursts, PC breakpoints, halted-only debug grant.
// Breakpoint hardware is present only when RUN_CTRL_BKPT_EN is defined.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = PC_W_DEF,
  parameter int unsigned BP_NUM      = BP_NUM_DEF,
  parameter int unsigned STEP_CNT_W  = STEP_CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DBNC_W      = DBNC_W_DEF
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   PAUSE,
  input  logic                   STEP,
  input  logic [STEP_CNT_W-1:0]  step_count,
  input  logic [BP_NUM-1:0]      bp_en,
  input  logic [BP_NUM*PC_W-1:0] bp_addr,
  output logic [BP_NUM-1:0]      bp_hit,
  run_ctrl_if.slave              rc
);

  logic pause_lvl, pause_rise, pause_fall;
  logic step_lvl, step_rise, step_fall;

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DBNC_W(DBNC_W)) u_pause_dbnc (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (PAUSE),
    .level (pause_lvl),
    .rise  (pause_rise),
    .fall  (pause_fall)
  );

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DBNC_W(DBNC_W)) u_step_dbnc (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (STEP),
    .level (step_lvl),
    .rise  (step_rise),
    .fall  (step_fall)
  );

  state_e                state_q, state_n;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_n;
  logic                  bp_mask_q, bp_mask_n;
  logic                  bp_latch_q, bp_latch_n;
  logic [BP_NUM-1:0]     bp_hit_q, bp_hit_n;
  logic                  halted_q, halted_n;
  logic                  dbg_grant_q, dbg_grant_n;
  logic [BP_NUM-1:0]     bp_vec;
  logic                  bp_match;
  logic                  run_en;
  logic                  unused_sigs;

`ifdef RUN_CTRL_BKPT_EN
  always_comb begin
    bp_vec = '0;
    for (int i = 0; i < int'(BP_NUM); i++)
      bp_vec[i] = bp_en[i] && (rc.cpu_PC == bp_addr[i*PC_W +: PC_W]);
  end
  // Mask suppresses the re-hit when resuming at the breakpoint PC itself.
  assign bp_match    = (|bp_vec) && !bp_mask_q;
  assign unused_sigs = ^{pause_rise, step_lvl, step_fall};
`else
  assign bp_vec      = '0;
  assign bp_match    = 1'b0;
  assign unused_sigs = ^{pause_rise, step_lvl, step_fall, pause_fall,
                         bp_en, bp_addr, rc.cpu_PC, bp_mask_q};
`endif

  // Next-state and pipeline-enable decode.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    bp_mask_n  = bp_mask_q;
    bp_latch_n = bp_latch_q;
    bp_hit_n   = bp_hit_q;
    run_en     = 1'b0;
    case (state_q)
      ST_RUN: begin
        run_en = !bp_match;
        if (bp_match) begin
          state_n    = ST_HALT;
          bp_hit_n   = bp_vec;
          bp_latch_n = 1'b1;
        end
        if (pause_lvl) state_n = ST_HALT;
      end
      ST_HALT: begin
        if (pause_fall) bp_latch_n = 1'b0;
        if (dbg_grant_q) begin
          state_n = ST_HALT;
        end else if (step_rise) begin
          state_n   = ST_STEPPING;
          cnt_n     = (step_count == '0) ? STEP_CNT_W'(1) : step_count;
          bp_mask_n = 1'b1;
        end else if (!pause_lvl && !bp_latch_q) begin
          state_n   = ST_RUN;
          bp_mask_n = 1'b1;
        end
      end
      ST_STEPPING: begin
        run_en = !bp_match;
        if (bp_match) begin
          state_n    = ST_HALT;
          bp_hit_n   = bp_vec;
          bp_latch_n = 1'b1;
        end else begin
          if (cnt_q > STEP_CNT_W'(1)) cnt_n = cnt_q - 1'b1;
          else                        state_n = ST_HALT;
        end
      end
      default: state_n = ST_RUN;
    endcase
    if (run_en) bp_mask_n = 1'b0;
    halted_n    = (state_n == ST_HALT);
    dbg_grant_n = (state_q == ST_HALT) && (state_n == ST_HALT) && rc.dbg_request;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      bp_mask_q   <= 1'b0;
      bp_latch_q  <= 1'b0;
      bp_hit_q    <= '0;
      halted_q    <= 1'b0;
      dbg_grant_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      bp_mask_q   <= bp_mask_n;
      bp_latch_q  <= bp_latch_n;
      bp_hit_q    <= bp_hit_n;
      halted_q    <= halted_n;
      dbg_grant_q <= dbg_grant_n;
    end
  end

  assign rc.cpu_en    = run_en;
  assign rc.halted    = halted_q;
  assign rc.dbg_grant = dbg_grant_q;
  assign bp_hit       = bp_hit_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl (DBNC_W=2, SYNC_STAGES=2); expected {halted,cpu_en,dbg_grant} go through a queue.
module tb_run_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        PAUSE;
  logic        STEP;
  logic [7:0]  step_count;
  logic [1:0]  bp_en;
  logic [15:0] bp_addr;
  logic [1:0]  bp_hit;

  run_ctrl_if #(.PC_W(8)) rc ();

  run_ctrl #(
    .PC_W(8), .BP_NUM(2), .STEP_CNT_W(8), .SYNC_STAGES(2), .DBNC_W(2)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .PAUSE      (PAUSE),
    .STEP       (STEP),
    .step_count (step_count),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .bp_hit     (bp_hit),
    .rc         (rc)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  task automatic test_reset();
    logic [2:0] exp, got;
    RST_N = 1'b0; PAUSE = 1'b0; STEP = 1'b0; step_count = 8'd3;
    bp_en = 2'b00; bp_addr = 16'h0000; rc.cpu_PC = 8'h00; rc.dbg_request = 1'b0;
    repeat (3) @(negedge CLK);
    exp_q.push_back(3'b010);
    exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL reset_outputs: got %b expected %b", got, exp); end
    n_vec++;
    if (bp_hit !== 2'b00) begin n_err++; $display("FAIL reset_bp_hit: got %b expected 00", bp_hit); end
    RST_N = 1'b1;
    for (int k = 1; k <= 4; k++) exp_q.push_back(3'b010);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL run_after_reset cycle %0d: got %b expected %b", k, got, exp); end
    end
  endtask

  task automatic test_pause();
    logic [2:0] exp, got;
    PAUSE = 1'b1;
    for (int k = 1; k <= 8; k++) exp_q.push_back((k >= 7) ? 3'b100 : 3'b010);
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL pause_latency cycle %0d: got %b expected %b", k, got, exp); end
    end
  endtask

  // STEP held 8 cycles; rising edge reaches the FSM 7 cycles after the pin.
  task automatic test_step(input logic [7:0] cnt, input int n_en);
    logic [2:0] exp, got;
    step_count = cnt;
    STEP = 1'b1;
    for (int k = 1; k <= 16; k++)
      exp_q.push_back((k >= 7 && k < 7 + n_en) ? 3'b010 : 3'b100);
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL step_cnt%0d cycle %0d: got %b expected %b", cnt, k, got, exp); end
      if (k == 8) STEP = 1'b0;
    end
  endtask

  task automatic test_glitch();
    logic [2:0] exp, got;
    step_count = 8'd3;
    STEP = 1'b1;
    for (int k = 1; k <= 20; k++) exp_q.push_back(3'b100);
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL step_glitch cycle %0d: got %b expected %b", k, got, exp); end
      STEP = (k < 10) ? ~STEP : 1'b0;
    end
  endtask

  task automatic test_dbg();
    logic [2:0] exp, got;
    @(negedge CLK);
    n_vec++;
    if (rc.dbg_grant !== 1'b0) begin n_err++; $display("FAIL dbg_idle: grant %b expected 0", rc.dbg_grant); end
    rc.dbg_request = 1'b1;
    exp_q.push_back(3'b101);
    @(negedge CLK);
    exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL dbg_grant_rise: got %b expected %b", got, exp); end
    STEP = 1'b1;
    for (int k = 1; k <= 18; k++) exp_q.push_back(3'b101);
    for (int k = 1; k <= 18; k++) begin
      @(negedge CLK);
      exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL dbg_step_blocked cycle %0d: got %b expected %b", k, got, exp); end
      if (k == 8) STEP = 1'b0;
    end
    rc.dbg_request = 1'b0;
    for (int k = 1; k <= 10; k++) exp_q.push_back(3'b100);
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL dbg_release cycle %0d: got %b expected %b", k, got, exp); end
    end
  endtask

  // cpu_PC behaves like a fetch register: advances on a clock edge where cpu_en was 1.
  task automatic test_bkpt();
    logic [2:0] exp, got;
    logic       en;
    int         guard;
    bit         hit;
    @(negedge CLK);
    bp_en = 2'b01; bp_addr = {8'h11, 8'h10}; rc.cpu_PC = 8'h0C; PAUSE = 1'b0;
    guard = 0;
    while (rc.cpu_en !== 1'b1 && guard < 20) begin @(negedge CLK); guard++; end
    n_vec++;
    if (guard != 7) begin n_err++; $display("FAIL resume_latency: %0d cycles expected 7", guard); end
`ifdef RUN_CTRL_BKPT_EN
    hit = 1'b0;
    for (int c = 0; c < 12 && !hit; c++) begin
      exp_q.push_back({1'b0, (rc.cpu_PC != 8'h10), 1'b0});
      exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL bp_ramp pc=%h: got %b expected %b", rc.cpu_PC, got, exp); end
      if (rc.cpu_PC == 8'h10) hit = 1'b1;
      else begin
        en = rc.cpu_en;
        @(posedge CLK); #1;
        if (en) rc.cpu_PC = rc.cpu_PC + 8'd1;
        @(negedge CLK);
      end
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL bp_reach: pc=%h never reached 10", rc.cpu_PC); end
    @(negedge CLK);
    exp_q.push_back(3'b100);
    exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL bp_halt: got %b expected %b", got, exp); end
    n_vec++;
    if (bp_hit !== 2'b01) begin n_err++; $display("FAIL bp_hit_set: got %b expected 01", bp_hit); end
    PAUSE = 1'b1;
    repeat (10) @(negedge CLK);
    n_vec++;
    if ({rc.halted, rc.cpu_en} !== 2'b10) begin n_err++; $display("FAIL bp_latch_hold: got %b expected 10", {rc.halted, rc.cpu_en}); end
    PAUSE = 1'b0;
    guard = 0;
    while (rc.cpu_en !== 1'b1 && guard < 20) begin @(negedge CLK); guard++; end
    n_vec++;
    if (guard != 8) begin n_err++; $display("FAIL bp_resume_latency: %0d cycles expected 8", guard); end
    for (int c = 0; c < 5; c++) begin
      exp_q.push_back(3'b010);
      exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL bp_no_rehit pc=%h: got %b expected %b", rc.cpu_PC, got, exp); end
      en = rc.cpu_en;
      @(posedge CLK); #1;
      if (en) rc.cpu_PC = rc.cpu_PC + 8'd1;
      @(negedge CLK);
    end
    n_vec++;
    if (bp_hit !== 2'b01) begin n_err++; $display("FAIL bp_hit_sticky: got %b expected 01", bp_hit); end
`else
    for (int c = 0; c < 9; c++) begin
      exp_q.push_back(3'b010);
      exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL nobp_ramp pc=%h: got %b expected %b", rc.cpu_PC, got, exp); end
      en = rc.cpu_en;
      @(posedge CLK); #1;
      if (en) rc.cpu_PC = rc.cpu_PC + 8'd1;
      @(negedge CLK);
    end
    n_vec++;
    if (bp_hit !== 2'b00) begin n_err++; $display("FAIL nobp_hit: got %b expected 00", bp_hit); end
`endif
    rc.dbg_request = 1'b1;
    for (int k = 1; k <= 3; k++) exp_q.push_back(3'b010);
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL dbg_while_run cycle %0d: got %b expected %b", k, got, exp); end
    end
    rc.dbg_request = 1'b0;
  endtask

  task automatic test_reset_mid_step();
    logic [2:0] exp, got;
    @(negedge CLK);
    bp_en = 2'b00; PAUSE = 1'b1;
    repeat (8) @(negedge CLK);
    n_vec++;
    if (rc.halted !== 1'b1) begin n_err++; $display("FAIL mid_step_prehalt: halted %b expected 1", rc.halted); end
    step_count = 8'd3; STEP = 1'b1;
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b010);
    repeat (7) @(negedge CLK);
    exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL mid_step_cnt3: got %b expected %b", got, exp); end
    @(negedge CLK);
    exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL mid_step_cnt2: got %b expected %b", got, exp); end
    #2;
    RST_N = 1'b0; STEP = 1'b0;
    exp_q.push_back(3'b010);
    #1;
    exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL async_reset_outputs: got %b expected %b", got, exp); end
    n_vec++;
    if (bp_hit !== 2'b00) begin n_err++; $display("FAIL async_reset_bp_hit: got %b expected 00", bp_hit); end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 1; k <= 8; k++) exp_q.push_back((k >= 7) ? 3'b100 : 3'b010);
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      exp = exp_q.pop_front(); got = {rc.halted, rc.cpu_en, rc.dbg_grant};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL post_reset_pause cycle %0d: got %b expected %b", k, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_pause();
    test_step(8'd3, 3);
    test_step(8'd0, 1);
    test_glitch();
    test_dbg();
    test_bkpt();
    test_reset_mid_step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached after %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
